// File: rtl/rob_dispatch_alloc.sv
// rob_dispatch_alloc: dispatch-side ROB slot allocator for a single-issue ROB.
// Accepts one decoded instruction per cycle over a valid/ready handshake. The
// accepted instruction is assigned the tail slot and written into the ROB one
// cycle later. Occupancy is tracked from commit pulses, and decode is stalled
// while the ROB is full.
// Optional feature macro: ROB_ALLOC_PERF_EN adds full_stall_cnt_o, a 32-bit
// count of cycles in which decode was held off by a full ROB.
module rob_dispatch_alloc #(
   parameter int unsigned ROB_NUM  = 64,
   parameter int unsigned ROB_SEL  = 6,
   parameter int unsigned ADDR_LEN = 32,
   parameter int unsigned REG_SEL  = 5
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   input  logic                dec_valid_i,
   output logic                dec_ready_o,
   input  logic [ADDR_LEN-1:0] dec_pc_i,
   input  logic                dec_dstvalid_i,
   input  logic [REG_SEL-1:0]  dec_dst_i,
   input  logic                rs_ready_i,
   input  logic                commit_1_i,
   output logic                dp1_o,
   output logic [ROB_SEL-1:0]  dp1_addr_o,
   output logic [ADDR_LEN-1:0] pc_dp1_o,
   output logic                dstvalid_dp1_o,
   output logic [REG_SEL-1:0]  dst_dp1_o,
   output logic [ROB_SEL:0]    rob_count_o,
   output logic                rob_full_o,
   output logic                rob_empty_o,
   output logic [ROB_SEL-1:0]  head_ptr_o
`ifdef ROB_ALLOC_PERF_EN
   ,
   output logic [31:0]         full_stall_cnt_o
`endif
);

   localparam int unsigned CNT_W = ROB_SEL + 1;
   localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(ROB_NUM);

   logic [ROB_SEL-1:0]  tail_q, tail_d;
   logic [ROB_SEL-1:0]  head_q, head_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic                dp1_q, dp1_d;
   logic [ROB_SEL-1:0]  addr_q, addr_d;
   logic [ADDR_LEN-1:0] pc_q, pc_d;
   logic                dstvalid_q, dstvalid_d;
   logic [REG_SEL-1:0]  dst_q, dst_d;

   logic                full;
   logic                empty;
   logic                accept;
   logic                commit_eff;

   // Handshake and status decode from registered occupancy only.
   always_comb begin
      full        = (count_q == COUNT_FULL);
      empty       = (count_q == '0);
      dec_ready_o = rs_ready_i & ~full;
      accept      = dec_valid_i & dec_ready_o;
      // A commit against an empty ROB is dropped so count never underflows.
      commit_eff  = commit_1_i & ~empty;
   end

   // Next-state for pointers, occupancy and the registered dispatch write.
   always_comb begin
      tail_d     = tail_q;
      head_d     = head_q;
      count_d    = count_q;
      dp1_d      = 1'b0;
      addr_d     = addr_q;
      pc_d       = pc_q;
      dstvalid_d = dstvalid_q;
      dst_d      = dst_q;

      if (accept) begin
         dp1_d      = 1'b1;
         addr_d     = tail_q;
         pc_d       = dec_pc_i;
         dstvalid_d = dec_dstvalid_i;
         dst_d      = dec_dst_i;
         // Power-of-two depth: natural overflow gives the 63->0 wrap.
         tail_d     = tail_q + ROB_SEL'(1);
      end

      if (commit_eff) begin
         head_d = head_q + ROB_SEL'(1);
      end

      unique case ({accept, commit_eff})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset drops any in-flight dispatch write.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         tail_q     <= '0;
         head_q     <= '0;
         count_q    <= '0;
         dp1_q      <= 1'b0;
         addr_q     <= '0;
         pc_q       <= '0;
         dstvalid_q <= 1'b0;
         dst_q      <= '0;
      end else begin
         tail_q     <= tail_d;
         head_q     <= head_d;
         count_q    <= count_d;
         dp1_q      <= dp1_d;
         addr_q     <= addr_d;
         pc_q       <= pc_d;
         dstvalid_q <= dstvalid_d;
         dst_q      <= dst_d;
      end
   end

   // Output mapping straight from registers.
   always_comb begin
      dp1_o          = dp1_q;
      dp1_addr_o     = addr_q;
      pc_dp1_o       = pc_q;
      dstvalid_dp1_o = dstvalid_q;
      dst_dp1_o      = dst_q;
      rob_count_o    = count_q;
      rob_full_o     = full;
      rob_empty_o    = empty;
      head_ptr_o     = head_q;
   end

`ifdef ROB_ALLOC_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count cycles where decode has work but the ROB is full; wraps at 2^32.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (dec_valid_i && full) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign full_stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
   // Flag illegal commits against an empty ROB and pointer/count drift.
   always_ff @(posedge clk_i) begin
      if (reset_ni) begin
         if (commit_1_i && empty) begin
            $error("rob_dispatch_alloc: commit_1_i asserted while ROB is empty");
         end
         if (tail_q != ROB_SEL'(head_q + count_q[ROB_SEL-1:0])) begin
            $error("rob_dispatch_alloc: tail/head/count invariant broken");
         end
         if (count_q > COUNT_FULL) begin
            $error("rob_dispatch_alloc: occupancy above ROB_NUM");
         end
      end
   end
`endif

endmodule

// File: tb/tb_rob_dispatch_alloc.sv
// Self-checking bench for rob_dispatch_alloc. The reference tracks total
// accepts and commits as plain integers; tail, head and occupancy follow from
// them by arithmetic. Directed phases pin literal values, random phases
// exercise full/empty/wrap behaviour.
module tb_rob_dispatch_alloc;

   localparam int ROBN = 64;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        dec_valid_i = 1'b0;
   logic        dec_ready_o;
   logic [31:0] dec_pc_i = '0;
   logic        dec_dstvalid_i = 1'b0;
   logic [4:0]  dec_dst_i = '0;
   logic        rs_ready_i = 1'b0;
   logic        commit_1_i = 1'b0;
   logic        dp1_o;
   logic [5:0]  dp1_addr_o;
   logic [31:0] pc_dp1_o;
   logic        dstvalid_dp1_o;
   logic [4:0]  dst_dp1_o;
   logic [6:0]  rob_count_o;
   logic        rob_full_o;
   logic        rob_empty_o;
   logic [5:0]  head_ptr_o;
`ifdef ROB_ALLOC_PERF_EN
   logic [31:0] full_stall_cnt_o;
`endif

   rob_dispatch_alloc dut (
      .clk_i          (clk_i),
      .reset_ni       (reset_ni),
      .dec_valid_i    (dec_valid_i),
      .dec_ready_o    (dec_ready_o),
      .dec_pc_i       (dec_pc_i),
      .dec_dstvalid_i (dec_dstvalid_i),
      .dec_dst_i      (dec_dst_i),
      .rs_ready_i     (rs_ready_i),
      .commit_1_i     (commit_1_i),
      .dp1_o          (dp1_o),
      .dp1_addr_o     (dp1_addr_o),
      .pc_dp1_o       (pc_dp1_o),
      .dstvalid_dp1_o (dstvalid_dp1_o),
      .dst_dp1_o      (dst_dp1_o),
      .rob_count_o    (rob_count_o),
      .rob_full_o     (rob_full_o),
      .rob_empty_o    (rob_empty_o),
      .head_ptr_o     (head_ptr_o)
`ifdef ROB_ALLOC_PERF_EN
      ,
      .full_stall_cnt_o (full_stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: totals since reset plus last dispatched payload.
   int          n_acc = 0;
   int          n_com = 0;
   logic        m_dp1 = 1'b0;
   logic [5:0]  m_addr = '0;
   logic [31:0] m_pc = '0;
   logic        m_dv = 1'b0;
   logic [4:0]  m_dst = '0;
   logic [31:0] m_stall = '0;
   bit          chk_en = 1'b1;

   function automatic int occ();
      return n_acc - n_com;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the reference, away from the rising edge.
   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("dp1", {63'd0, dp1_o}, {63'd0, m_dp1});
         chk("dp1_addr", {58'd0, dp1_addr_o}, {58'd0, m_addr});
         chk("pc_dp1", {32'd0, pc_dp1_o}, {32'd0, m_pc});
         chk("dstvalid", {63'd0, dstvalid_dp1_o}, {63'd0, m_dv});
         chk("dst", {59'd0, dst_dp1_o}, {59'd0, m_dst});
         chk("count", {57'd0, rob_count_o}, 64'(occ()));
         chk("full", {63'd0, rob_full_o}, {63'd0, (occ() == ROBN)});
         chk("empty", {63'd0, rob_empty_o}, {63'd0, (occ() == 0)});
         chk("head", {58'd0, head_ptr_o}, 64'(n_com % ROBN));
         chk("ready", {63'd0, dec_ready_o}, {63'd0, (rs_ready_i && occ() != ROBN)});
`ifdef ROB_ALLOC_PERF_EN
         chk("stall_cnt", {32'd0, full_stall_cnt_o}, {32'd0, m_stall});
`endif
      end
   end

   // One cycle: called at a falling edge, returns at the next falling edge.
   task automatic step(input bit v, input bit rs, input bit cm, input logic [31:0] pc,
                       input bit dv, input logic [4:0] dst);
      bit acc;
      #1;
      dec_valid_i    = v;
      rs_ready_i     = rs;
      commit_1_i     = cm;
      dec_pc_i       = pc;
      dec_dstvalid_i = dv;
      dec_dst_i      = dst;
      acc = v && rs && (occ() != ROBN);
      @(posedge clk_i);
      if (v && occ() == ROBN) m_stall++;
      if (acc) begin
         m_dp1  = 1'b1;
         m_addr = 6'(n_acc % ROBN);
         m_pc   = pc;
         m_dv   = dv;
         m_dst  = dst;
         n_acc++;
      end else begin
         m_dp1 = 1'b0;
      end
      if (cm) n_com++;
      @(negedge clk_i);
   endtask

   task automatic rand_step(input int v_pct, input int c_pct);
      bit v;
      bit rs;
      bit cm;
      v  = ($urandom_range(0, 99) < v_pct);
      rs = ($urandom_range(0, 99) < 85);
      cm = (occ() > 0) && ($urandom_range(0, 99) < c_pct);
      step(v, rs, cm, $urandom, 1'($urandom), 5'($urandom));
   endtask

   // Asynchronous reset asserted between edges; called and returns at a falling edge.
   task automatic do_reset();
      #2;
      reset_ni    = 1'b0;
      dec_valid_i = 1'b0;
      commit_1_i  = 1'b0;
      n_acc = 0;
      n_com = 0;
      m_dp1 = 1'b0;
      m_addr = '0;
      m_pc = '0;
      m_dv = 1'b0;
      m_dst = '0;
      m_stall = '0;
      #1;
      chk("rst_dp1", {63'd0, dp1_o}, 64'd0);
      chk("rst_addr", {58'd0, dp1_addr_o}, 64'd0);
      chk("rst_pc", {32'd0, pc_dp1_o}, 64'd0);
      chk("rst_count", {57'd0, rob_count_o}, 64'd0);
      chk("rst_empty", {63'd0, rob_empty_o}, 64'd1);
      chk("rst_full", {63'd0, rob_full_o}, 64'd0);
      chk("rst_head", {58'd0, head_ptr_o}, 64'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      #2;
      reset_ni = 1'b1;
      @(negedge clk_i);
   endtask

   initial begin
      @(negedge clk_i);
      do_reset();

      // Idle after reset: ready follows rs_ready_i.
      step(0, 1, 0, 32'h0, 0, 5'd0);
      chk("idle_ready_hi", {63'd0, dec_ready_o}, 64'd1);
      chk("idle_dp1", {63'd0, dp1_o}, 64'd0);
      step(0, 0, 0, 32'h0, 0, 5'd0);
      chk("idle_ready_lo", {63'd0, dec_ready_o}, 64'd0);

      // Fill the ROB back to back; each write lands on the slot in order.
      for (int i = 0; i < ROBN; i++) begin
         step(1, 1, 0, 32'h1000 + 32'(i * 4), 1, 5'(i));
         chk("fill_addr", {58'd0, dp1_addr_o}, 64'(i));
         chk("fill_dp1", {63'd0, dp1_o}, 64'd1);
      end
      chk("full_count", {57'd0, rob_count_o}, 64'd64);
      chk("full_flag", {63'd0, rob_full_o}, 64'd1);
      chk("full_ready", {63'd0, dec_ready_o}, 64'd0);
      // 65th request is refused, and counts as a stall cycle.
      step(1, 1, 0, 32'hdead, 1, 5'd1);
      chk("full_no_acc", {63'd0, dp1_o}, 64'd0);
      chk("full_hold", {57'd0, rob_count_o}, 64'd64);
      chk("full_hold_pc", {32'd0, pc_dp1_o}, 64'h10fc);

      // One commit from full frees a slot; next accept wraps to slot 0.
      step(0, 1, 1, 32'h0, 0, 5'd0);
      chk("free_count", {57'd0, rob_count_o}, 64'd63);
      chk("free_ready", {63'd0, dec_ready_o}, 64'd1);
      step(1, 1, 0, 32'h2000, 0, 5'd3);
      chk("wrap_addr", {58'd0, dp1_addr_o}, 64'd0);
      chk("wrap_head", {58'd0, head_ptr_o}, 64'd1);

      // Accept and commit together at count 10.
      do_reset();
      for (int i = 0; i < 10; i++) step(1, 1, 0, 32'(i), 0, 5'd0);
      step(1, 1, 1, 32'h3000, 1, 5'd7);
      chk("ac_count", {57'd0, rob_count_o}, 64'd10);
      chk("ac_addr", {58'd0, dp1_addr_o}, 64'd10);
      chk("ac_head", {58'd0, head_ptr_o}, 64'd1);

      // Issue stage not ready: no accept, tail holds.
      step(1, 0, 0, 32'h4000, 1, 5'd2);
      chk("rs_block_dp1", {63'd0, dp1_o}, 64'd0);
      step(1, 1, 0, 32'h4004, 1, 5'd2);
      chk("rs_resume_addr", {58'd0, dp1_addr_o}, 64'd11);

      // Random traffic biased to reach full, then to drain, then balanced.
      for (int i = 0; i < 1500; i++) rand_step(80, 25);
      for (int i = 0; i < 1500; i++) rand_step(40, 70);
      for (int i = 0; i < 3000; i++) rand_step(65, 55);

      // Mid-stream reset, then the first accept lands in slot 0.
      do_reset();
      step(1, 1, 0, 32'h5000, 1, 5'd9);
      chk("post_rst_addr", {58'd0, dp1_addr_o}, 64'd0);
      chk("post_rst_pc", {32'd0, pc_dp1_o}, 64'h5000);
      for (int i = 0; i < 500; i++) rand_step(70, 50);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
